fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS core; successor to the fixed two-operand, two-level forwarding logic. Resolves up to NSRC source operands per instruction against EX/MEM, MEM/WB and an internal WB-hold level. Detects load-use hazards and tracks one in-flight multi-cycle multiply/divide with a latency counter. Sits beside the ID/EX register and drives the EX operand muxes plus the IF/ID stall and ID/EX bubble controls.

## Interface
- REG_AW, 5, register address width
- NSRC, 2, source operands per instruction (1..4)
- MUL_LAT, 4, multi-cycle unit latency in cycles (2..16)

- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- id_ex_src  in  NSRC*REG_AW  EX-stage source addresses, operand i at [i*REG_AW +: REG_AW]
- if_id_src  in  NSRC*REG_AW  ID-stage source addresses, same packing
- id_ex_mem_read  in  1  EX-stage instruction is a load
- id_ex_rd  in  REG_AW  EX-stage destination
- ex_mem_reg_write, mem_wb_reg_write  in  1  write enables per stage
- ex_mem_rd, mem_wb_rd  in  REG_AW  destinations per stage
- mul_issue  in  1  EX-stage multi-cycle op issues this cycle
- id_is_mul  in  1  ID-stage instruction is a multi-cycle op
- fwd_sel  out  NSRC*2  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB-hold
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control; equals stall
- mul_busy  out  1  multi-cycle unit occupied
- mul_done  out  1  result writes back this cycle

## Operation
- Forward priority per operand i, first match wins; register 0 never matches:
  - EX/MEM: ex_mem_reg_write && ex_mem_rd == src_i -> 10
  - MEM/WB: mem_wb_reg_write && mem_wb_rd == src_i -> 01
  - WB-hold: hold_valid && hold_rd == src_i -> 11
  - else 00
- WB-hold register: each cycle captures hold_valid <= mem_wb_reg_write && mem_wb_rd != 0, hold_rd <= mem_wb_rd. Covers regfiles without write-through.
- Load-use: id_ex_mem_read && id_ex_rd != 0 && id_ex_rd equals any if_id_src -> stall.
- Multi-cycle FSM, states IDLE/BUSY:
  - IDLE, mul_issue: -> BUSY, cnt <= MUL_LAT-1, mul_rd <= id_ex_rd.
  - BUSY: cnt decrements each cycle; mul_done = BUSY && cnt == 0; at cnt == 0 -> IDLE, unless mul_issue the same cycle, which re-enters BUSY with the new rd (back-to-back).
  - mul_issue in BUSY with cnt != 0: ignored, state unchanged.
  - mul_rd == 0: counter still runs; no RAW stall.
- Multi-cycle stall: BUSY && cnt != 0 && (id_is_mul || mul_rd != 0 && mul_rd equals any if_id_src).
- stall = load-use || multi-cycle stall; bubble = stall.

## Timing
- fwd_sel, stall, bubble, mul_done combinational from inputs and registered state; zero added latency.
- Registered state: hold_valid, hold_rd, FSM, cnt, mul_rd; all clear asynchronously on reset_n low.
- Reset values: mul_busy 0, mul_done 0. fwd_sel carries no 11. stall is asserted only by load-use.
- Reset mid-operation: in-flight multi-cycle op abandoned, no mul_done.
- Multi-cycle op issued at cycle t: mul_busy high t+1..t+MUL_LAT, mul_done at t+MUL_LAT, dependent ID instruction released at t+MUL_LAT.

## Configuration
- FWD_WB_HOLD_EN defined: WB-hold level present, code 11 possible.
- Undefined: hold registers absent, code 11 never produced, three-level priority only.

## Structure
- Package fwd_pkg: fwd_sel_t encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_HOLD), FSM state enum.
- Sub-module fwd_match: one operand's priority compare, instantiated NSRC times via generate.

## Test plan
- ex_mem_rd=5 write and mem_wb_rd=5 write, id_ex_src0=5 -> fwd_sel[1:0]=10; EX/MEM write disabled -> 01.
- ex_mem_rd=0 write, id_ex_src1=0 -> fwd_sel[3:2]=00.
- FWD_WB_HOLD_EN: mem_wb_rd=7 write at t, id_ex_src0=7 at t+1 -> 11; undefined -> 00.
- id_ex_mem_read, id_ex_rd=3, if_id_src1=3 -> stall=bubble=1 for one cycle; if_id_src1=4 -> 0.
- MUL_LAT=4, mul_issue rd=9 at t, if_id_src0=9 -> stall t+1..t+3, mul_done at t+4, stall low at t+4.
- reset_n low at t+2 of a busy op -> mul_busy=0 immediately, no mul_done.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand-select codes and
// the multi-cycle unit state.
package fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10,
        FWD_HOLD  = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_t;

endpackage

// File: rtl/fwd_match.sv
// One operand's forwarding priority compare: EX/MEM, then MEM/WB, then the
// WB-hold level; register 0 is never forwarded.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              hold_valid,
    input  logic [REG_AW-1:0] hold_rd,
    output logic [1:0]        fwd_sel
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    // Priority select, first match wins
    always_comb begin
        fwd_sel = FWD_RF;
        if (src == REG_ZERO) begin
            fwd_sel = FWD_RF;
        end else if (ex_mem_reg_write && (ex_mem_rd == src)) begin
            fwd_sel = FWD_EXMEM;
        end else if (mem_wb_reg_write && (mem_wb_rd == src)) begin
            fwd_sel = FWD_MEMWB;
        end else if (hold_valid && (hold_rd == src)) begin
            fwd_sel = FWD_HOLD;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: per-operand forward selects, load-use and
// multi-cycle stalls. Define FWD_WB_HOLD_EN to add the WB-hold forward level.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NSRC    = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NSRC*REG_AW-1:0] id_ex_src,
    input  logic [NSRC*REG_AW-1:0] if_id_src,
    input  logic                   id_ex_mem_read,
    input  logic [REG_AW-1:0]      id_ex_rd,
    input  logic                   ex_mem_reg_write,
    input  logic                   mem_wb_reg_write,
    input  logic [REG_AW-1:0]      ex_mem_rd,
    input  logic [REG_AW-1:0]      mem_wb_rd,
    input  logic                   mul_issue,
    input  logic                   id_is_mul,
    output logic [NSRC*2-1:0]      fwd_sel,
    output logic                   stall,
    output logic                   bubble,
    output logic                   mul_busy,
    output logic                   mul_done
);

    localparam int                CNT_W    = $clog2(MUL_LAT);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MUL_LAT - 1);

    logic              hold_valid_s;
    logic [REG_AW-1:0] hold_rd_s;

`ifdef FWD_WB_HOLD_EN
    logic              hold_valid_r;
    logic [REG_AW-1:0] hold_rd_r;

    // WB-hold level: one extra cycle of the MEM/WB write for regfiles without write-through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_r <= 1'b0;
            hold_rd_r    <= REG_ZERO;
        end else begin
            hold_valid_r <= mem_wb_reg_write && (mem_wb_rd != REG_ZERO);
            hold_rd_r    <= mem_wb_rd;
        end
    end

    assign hold_valid_s = hold_valid_r;
    assign hold_rd_s    = hold_rd_r;
`else
    assign hold_valid_s = 1'b0;
    assign hold_rd_s    = REG_ZERO;
`endif

    for (genvar i = 0; i < NSRC; i++) begin : g_match
        fwd_match #(.REG_AW(REG_AW)) u_match (
            .src              (id_ex_src[i*REG_AW +: REG_AW]),
            .ex_mem_reg_write (ex_mem_reg_write),
            .ex_mem_rd        (ex_mem_rd),
            .mem_wb_reg_write (mem_wb_reg_write),
            .mem_wb_rd        (mem_wb_rd),
            .hold_valid       (hold_valid_s),
            .hold_rd          (hold_rd_s),
            .fwd_sel          (fwd_sel[i*2 +: 2])
        );
    end

    mul_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [REG_AW-1:0] mul_rd_r, mul_rd_nxt_s;
    logic              mul_done_s;
    logic              load_use_s;
    logic              mul_raw_s;
    logic              mul_stall_s;

    // Multi-cycle unit state, counter and destination registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= MUL_IDLE;
            cnt_r    <= CNT_ZERO;
            mul_rd_r <= REG_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            mul_rd_r <= mul_rd_nxt_s;
        end
    end

    // Next state: issue only accepted when idle or on the completing cycle
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        mul_rd_nxt_s = mul_rd_r;
        mul_done_s   = 1'b0;
        case (state_r)
            MUL_IDLE: begin
                if (mul_issue) begin
                    state_nxt_s  = MUL_BUSY;
                    cnt_nxt_s    = CNT_LOAD;
                    mul_rd_nxt_s = id_ex_rd;
                end else begin
                    state_nxt_s  = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    mul_done_s = 1'b1;
                    if (mul_issue) begin
                        state_nxt_s  = MUL_BUSY;
                        cnt_nxt_s    = CNT_LOAD;
                        mul_rd_nxt_s = id_ex_rd;
                    end else begin
                        state_nxt_s  = MUL_IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = MUL_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Source-address compares against the load and multi-cycle destinations
    always_comb begin
        load_use_s = 1'b0;
        mul_raw_s  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            load_use_s = load_use_s | (id_ex_mem_read && (id_ex_rd != REG_ZERO) &&
                                       (if_id_src[i*REG_AW +: REG_AW] == id_ex_rd));
            mul_raw_s  = mul_raw_s | ((mul_rd_r != REG_ZERO) &&
                                      (if_id_src[i*REG_AW +: REG_AW] == mul_rd_r));
        end
    end

    assign mul_stall_s = (state_r == MUL_BUSY) && (cnt_r != CNT_ZERO) && (id_is_mul || mul_raw_s);
    assign stall       = load_use_s | mul_stall_s;
    assign bubble      = stall;
    assign mul_busy    = (state_r == MUL_BUSY);
    assign mul_done    = mul_done_s;

endmodule
